// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic imm;
    logic ill;
  } op_class_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode to one-hot instruction class; purely combinational, no backpressure.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  output logic [6:0] op_class
);

  op_class_t cls;

  always_comb begin
    cls = '0;
    case (op)
      OP_R:            cls.r   = 1'b1;
      OP_LW:           cls.lw  = 1'b1;
      OP_SW:           cls.sw  = 1'b1;
      OP_BEQ:          cls.beq = 1'b1;
      OP_J:            cls.j   = 1'b1;
      OP_ADDI, OP_ORI: cls.imm = 1'b1;
      default:         cls.ill = 1'b1;
    endcase
    op_class = cls;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM: Moore datapath controls per state, 2-5 cycles per instruction.
// Stalls in IF/MRD/MWR until mem_ready; counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        ExtZero,
  output logic        bad_op,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  op_class_t   cls;
  logic        is_ori;
  logic        retire;
  logic        pc_write, pc_write_cond, ir_write, reg_write, mem_write;
  logic        unused_zero;

  // The branch decision (zero & PCWriteCond) is made in the datapath.
  assign unused_zero = zero;

  mc_decode u_decode (
    .op       (op),
    .op_class (cls)
  );

  assign is_ori = (op == OP_ORI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (cls.lw || cls.sw) state_d = S_MADR;
        else if (cls.r)       state_d = S_REX;
        else if (cls.beq)     state_d = S_BR;
        else if (cls.j)       state_d = S_JMP;
        else if (cls.imm)     state_d = S_IEX;
        else                  state_d = S_IF;
      end
      S_MADR: state_d = cls.lw ? S_MRD : S_MWR;
      S_MRD:  if (mem_ready) state_d = S_MWB;
      S_MWR: begin
        if (mem_ready) begin
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_MWB, S_RWB, S_IWB, S_BR, S_JMP: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_REX:  state_d = S_RWB;
      S_IEX:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    PCSource      = PCSRC_ALU;
    ALUSrcB       = SRCB_B;
    ALUOp         = ALUOP_ADD;
    ExtZero       = 1'b0;
    bad_op        = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_ID: begin
        ALUSrcB = SRCB_IMMSH;
        bad_op  = cls.ill;
      end
      S_MADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      S_MWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        PCSource      = PCSRC_ALUOUT;
      end
      S_JMP: begin
        pc_write = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = is_ori ? ALUOP_ORI : ALUOP_ADD;
        ExtZero = is_ori;
      end
      S_IWB: begin
        reg_write = 1'b1;
        ExtZero   = is_ori;
      end
      default: ;
    endcase
  end

  // State is already IF during reset; only the architectural writes need masking.
  assign PCWrite     = pc_write      & ~rst;
  assign PCWriteCond = pc_write_cond & ~rst;
  assign IRWrite     = ir_write      & ~rst;
  assign RegWrite    = reg_write     & ~rst;
  assign MemWrite    = mem_write     & ~rst;
  assign instret     = instret_q;

endmodule
